// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared types and constants for the push-button debouncer.
//   - key_state_t           : per-key debounce FSM state
//   - DEFAULT_STABLE_CYCLES : 10 ms at 50 MHz
//   - cnt_width()           : width of the per-key stability counter
package key_debouncer_pkg;

    typedef enum logic [1:0] {
        UP         = 2'd0,
        PRESS_PEND = 2'd1,
        DOWN       = 2'd2,
        REL_PEND   = 2'd3
    } key_state_t;

    localparam int DEFAULT_STABLE_CYCLES = 500000;

    // Counter only has to reach stable_cycles-1, so clog2 bits suffice;
    // never return a zero width.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if
//   Bundles the key-side and consumer-side signals of the debouncer.
//   - key_raw       : raw active-low pin levels (driven by master)
//   - key_out       : debounced active-low levels
//   - press_pulse   : one-cycle pulse per accepted press
//   - release_pulse : one-cycle pulse per accepted release
//   master : the surrounding system (drives pins, consumes outputs)
//   slave  : the debouncer itself
interface key_debouncer_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_raw;
    logic [N_KEYS-1:0] key_out;
    logic [N_KEYS-1:0] press_pulse;
    logic [N_KEYS-1:0] release_pulse;

    modport master (
        output key_raw,
        input  key_out,
        input  press_pulse,
        input  release_pulse
    );

    modport slave (
        input  key_raw,
        output key_out,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debounce_chan.sv
// key_debounce_chan
//   One key: two-flop synchronizer, UP/PRESS_PEND/DOWN/REL_PEND FSM and
//   stability counter. All outputs are registered.
//   Ports:
//   - clk, reset_n  : clock, asynchronous active-low reset
//   - key_raw       : raw active-low pin, asynchronous to clk
//   - key_out       : debounced active-low level
//   - press_pulse   : one cycle high on an accepted press
//   - release_pulse : one cycle high on an accepted release
module key_debounce_chan
    import key_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int            CW      = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    // NOTE: two back-to-back flops give sync1 a full cycle to resolve
    // metastability; nothing but sync2 may ever look at the pin value.
    logic sync1;
    logic sync2;

    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_d;
    logic          press_d;
    logic          release_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            state_q       <= UP;
            cnt_q         <= '0;
            key_out       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= key_raw;
            sync2         <= sync1;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_out       <= key_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_out;   // PEND states hold the previous level
        press_d   = 1'b0;
        release_d = 1'b0;

        unique case (state_q)
            UP: begin
                if (!sync2) begin
                    state_d = PRESS_PEND;
                    cnt_d   = '0;
                end
            end

            PRESS_PEND: begin
                if (sync2) begin
                    state_d = UP;          // bounce: back out
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = DOWN;
                    key_d   = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DOWN: begin
                if (sync2) begin
                    state_d = REL_PEND;
                    cnt_d   = '0;
                end
            end

            REL_PEND: begin
                if (!sync2) begin
                    state_d = DOWN;        // bounce: back out
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = UP;
                    key_d     = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = UP;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   Synchronizes and debounces N_KEYS active-low push-buttons for the
//   KEYs PIO and produces per-key press/release pulses for local logic.
//   Ports:
//   - clk     : system clock (50 MHz)
//   - reset_n : asynchronous active-low reset
//   - bus     : key_debouncer_if slave (key_raw in; key_out,
//               press_pulse, release_pulse out)
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic          clk,
    input  logic          reset_n,
    key_debouncer_if.slave bus
);

    logic [N_KEYS-1:0] key_out_w;
    logic [N_KEYS-1:0] press_w;
    logic [N_KEYS-1:0] release_w;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .key_raw       (bus.key_raw[i]),
            .key_out       (key_out_w[i]),
            .press_pulse   (press_w[i]),
            .release_pulse (release_w[i])
        );
    end

    assign bus.key_out       = key_out_w;
    assign bus.press_pulse   = press_w;
    assign bus.release_pulse = release_w;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Directed bench for key_debouncer with STABLE_CYCLES = 8, so an
//   accepted transition appears 10 edges after the first sampling edge.
module tb_key_debouncer;

    localparam int N_KEYS = 4;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    key_debouncer_if #(.N_KEYS(N_KEYS)) bus ();

    key_debouncer #(
        .N_KEYS        (N_KEYS),
        .STABLE_CYCLES (8)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges during which key_out must stay at exp_out with no pulses.
    task automatic hold(input int n, input logic [3:0] exp_out, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_hold_out"}, 32'(bus.key_out), 32'(exp_out));
            check({tag, "_hold_pulse"}, 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
        end
    endtask

    // Acceptance edge, then the following edge where pulses must be gone.
    task automatic accept(input logic [3:0] exp_out, input logic [3:0] exp_press,
                          input logic [3:0] exp_rel, input string tag);
        step();
        check({tag, "_acc_out"}, 32'(bus.key_out), 32'(exp_out));
        check({tag, "_acc_press"}, 32'(bus.press_pulse), 32'(exp_press));
        check({tag, "_acc_rel"}, 32'(bus.release_pulse), 32'(exp_rel));
        step();
        check({tag, "_post_out"}, 32'(bus.key_out), 32'(exp_out));
        check({tag, "_post_pulse"}, 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        bus.key_raw = 4'hF;

        // Reset state
        repeat (3) step();
        check("rst_out", 32'(bus.key_out), 32'hF);
        check("rst_press", 32'(bus.press_pulse), 32'h0);
        check("rst_rel", 32'(bus.release_pulse), 32'h0);
        reset_n = 1'b1;
        hold(12, 4'hF, "idle");

        // Clean press on key 0, then release path
        bus.key_raw = 4'b1110;
        hold(10, 4'hF, "press0");
        accept(4'b1110, 4'b0001, 4'b0000, "press0");
        bus.key_raw = 4'hF;
        hold(10, 4'b1110, "rel0");
        accept(4'hF, 4'b0000, 4'b0001, "rel0");

        // Bounce on key 1: low 5, high 2, then low and held
        bus.key_raw = 4'b1101;
        hold(5, 4'hF, "bounce_lo");
        bus.key_raw = 4'hF;
        hold(2, 4'hF, "bounce_hi");
        bus.key_raw = 4'b1101;
        hold(10, 4'hF, "bounce_final");
        accept(4'b1101, 4'b0010, 4'b0000, "bounce");
        hold(5, 4'b1101, "bounce_single");
        bus.key_raw = 4'hF;
        hold(10, 4'b1101, "rel1");
        accept(4'hF, 4'b0000, 4'b0010, "rel1");

        // Threshold on key 2: 8 low edges rejected
        bus.key_raw = 4'b1011;
        hold(8, 4'hF, "thr8_lo");
        bus.key_raw = 4'hF;
        hold(12, 4'hF, "thr8_after");

        // 9 low edges accepted (edge 10), release accepted at edge 19
        bus.key_raw = 4'b1011;
        hold(9, 4'hF, "thr9_lo");
        bus.key_raw = 4'hF;
        hold(1, 4'hF, "thr9_edge9");
        accept(4'b1011, 4'b0100, 4'b0000, "thr9_press");
        hold(7, 4'b1011, "thr9_relpend");
        accept(4'hF, 4'b0000, 4'b0100, "thr9_rel");

        // Simultaneous press/release of keys 0 and 3
        bus.key_raw = 4'b0110;
        hold(10, 4'hF, "simul");
        accept(4'b0110, 4'b1001, 4'b0000, "simul_press");
        bus.key_raw = 4'hF;
        hold(10, 4'b0110, "simul_rel");
        accept(4'hF, 4'b0000, 4'b1001, "simul_rel");

        // Reset while key 0 is DOWN and key 2 is in PRESS_PEND with cnt = 5
        bus.key_raw = 4'b1110;
        hold(10, 4'hF, "pre_rst");
        accept(4'b1110, 4'b0001, 4'b0000, "pre_rst");
        bus.key_raw = 4'b1010;
        hold(8, 4'b1110, "pend2");
        reset_n = 1'b0;
        #1;
        check("midrst_out", 32'(bus.key_out), 32'hF);
        check("midrst_pulse", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("inrst_out", 32'(bus.key_out), 32'hF);
            check("inrst_pulse", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
        end
        reset_n = 1'b1;
        hold(10, 4'hF, "post_rst");
        accept(4'b1010, 4'b0101, 4'b0000, "post_rst");
        bus.key_raw = 4'hF;
        hold(10, 4'b1010, "post_rst_rel");
        accept(4'hF, 4'b0000, 4'b0101, "post_rst_rel");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
